// File: rtl/aq_vidu_vid_wbt_mentry_pkg.sv
// Shared configuration for the vector write-back table entry.
// Holds the producer type encodings and the default port counts and counter width.
// Optional feature macro: AQ_VIDU_WBT_PROT_CHK_EN (protocol error checking in the entry).
package aq_vidu_vid_wbt_mentry_pkg;

    localparam logic WBT_TYPE_VLSU  = 1'b1;
    localparam logic WBT_TYPE_OTHER = 1'b0;

    localparam int unsigned DEF_CREATE_PORTS = 2;
    localparam int unsigned DEF_WB_PORTS     = 2;
    localparam int unsigned DEF_CNT_W        = 2;

endpackage

// File: rtl/aq_vidu_vid_wbt_mentry_if.sv
// Interface bundling the create/write-back/flush inputs and the read-out of one WBT entry.
//   master : dispatch/rtu/issue side (drives strobes, observes status)
//   slave  : the entry itself
// Optional feature macro: AQ_VIDU_WBT_PROT_CHK_EN (gives err meaning; otherwise err is 0).
interface aq_vidu_vid_wbt_mentry_if
    import aq_vidu_vid_wbt_mentry_pkg::*;
#(
    parameter int unsigned CREATE_PORTS = DEF_CREATE_PORTS,
    parameter int unsigned WB_PORTS     = DEF_WB_PORTS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) ();

    logic [CREATE_PORTS-1:0] create_en;
    logic [CREATE_PORTS-1:0] create_type;
    logic [WB_PORTS-1:0]     wb_en;
    logic [WB_PORTS-1:0]     wb_type;
    logic                    rtu_vidu_flush_wbt;
    logic                    rtu_yy_xx_async_flush;

    logic                    rd_vld;
    logic                    rd_type;
    logic [CNT_W-1:0]        rd_cnt;
    logic                    rd_lsu_pend;
    logic                    full;
    logic                    wb_debug;
    logic                    err;

    modport master (
        output create_en, create_type, wb_en, wb_type,
               rtu_vidu_flush_wbt, rtu_yy_xx_async_flush,
        input  rd_vld, rd_type, rd_cnt, rd_lsu_pend, full, wb_debug, err
    );

    modport slave (
        input  create_en, create_type, wb_en, wb_type,
               rtu_vidu_flush_wbt, rtu_yy_xx_async_flush,
        output rd_vld, rd_type, rd_cnt, rd_lsu_pend, full, wb_debug, err
    );

endinterface

// File: rtl/aq_vidu_wbt_popcnt.sv
// Population count of a strobe vector.
//   vec_i : input bit vector (WIDTH bits)
//   cnt_o : number of set bits in vec_i
// Optional feature macro: AQ_VIDU_WBT_PROT_CHK_EN (not used here).
module aq_vidu_wbt_popcnt #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [OUT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_o = cnt_o + OUT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/aq_vidu_vid_wbt_mentry.sv
// Vector write-back table entry: counts outstanding producers of one vreg,
// separately counts outstanding VLSU producers, and reports readiness.
//   forever_cpuclk : core clock
//   cpurst_b       : async active-low reset
//   bus (slave)    : create/wb strobes and types, two flushes in; rd_vld, rd_type,
//                    rd_cnt, rd_lsu_pend, full, wb_debug, err out
// Optional feature macro: AQ_VIDU_WBT_PROT_CHK_EN builds the sticky protocol error
// (overflow, underflow, VLSU wb with no VLSU producer); undefined ties err to 0.
module aq_vidu_vid_wbt_mentry
    import aq_vidu_vid_wbt_mentry_pkg::*;
#(
    parameter int unsigned CREATE_PORTS = DEF_CREATE_PORTS,
    parameter int unsigned WB_PORTS     = DEF_WB_PORTS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst_b,
    aq_vidu_vid_wbt_mentry_if.slave   bus
);

    localparam int unsigned MAX_PROD = (1 << CNT_W) - 1;
    localparam int unsigned NC_W     = $clog2(CREATE_PORTS + 1);
    localparam int unsigned NW_W     = $clog2(WB_PORTS + 1);
    localparam int unsigned SUM_W    = CNT_W + ((NC_W > NW_W) ? NC_W : NW_W) + 1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        lsu_q, lsu_d;
    logic                    type_q, type_d;
    logic [NC_W-1:0]         nc, ncl;
    logic [NW_W-1:0]         nw, nwl;
    logic [CREATE_PORTS-1:0] create_lsu;
    logic [WB_PORTS-1:0]     wb_lsu;
    logic                    flush;

    // Strobes that belong to VLSU producers.
    always_comb begin
        for (int unsigned i = 0; i < CREATE_PORTS; i++) begin
            create_lsu[i] = bus.create_en[i] & (bus.create_type[i] == WBT_TYPE_VLSU);
        end
        for (int unsigned i = 0; i < WB_PORTS; i++) begin
            wb_lsu[i] = bus.wb_en[i] & (bus.wb_type[i] == WBT_TYPE_VLSU);
        end
    end

    aq_vidu_wbt_popcnt #(.WIDTH(CREATE_PORTS), .OUT_W(NC_W)) u_pc_nc  (.vec_i(bus.create_en), .cnt_o(nc));
    aq_vidu_wbt_popcnt #(.WIDTH(WB_PORTS),     .OUT_W(NW_W)) u_pc_nw  (.vec_i(bus.wb_en),     .cnt_o(nw));
    aq_vidu_wbt_popcnt #(.WIDTH(CREATE_PORTS), .OUT_W(NC_W)) u_pc_ncl (.vec_i(create_lsu),    .cnt_o(ncl));
    aq_vidu_wbt_popcnt #(.WIDTH(WB_PORTS),     .OUT_W(NW_W)) u_pc_nwl (.vec_i(wb_lsu),        .cnt_o(nwl));

    assign flush = bus.rtu_vidu_flush_wbt | bus.rtu_yy_xx_async_flush;

    // cur + add - sub, computed wide and clamped into [0, MAX_PROD] so it never wraps.
    function automatic logic [CNT_W-1:0] clamp_upd(input logic [CNT_W-1:0] cur,
                                                   input logic [SUM_W-1:0] add_n,
                                                   input logic [SUM_W-1:0] sub_n);
        logic [SUM_W-1:0] tot;
        tot = SUM_W'(cur) + add_n;
        if (sub_n > tot) begin
            return '0;
        end
        tot = tot - sub_n;
        if (tot > SUM_W'(MAX_PROD)) begin
            return CNT_W'(MAX_PROD);
        end
        return CNT_W'(tot);
    endfunction

    // Next-state: flush beats any same-cycle create/wb.
    always_comb begin
        cnt_d  = cnt_q;
        lsu_d  = lsu_q;
        type_d = type_q;
        if (flush) begin
            cnt_d  = '0;
            lsu_d  = '0;
            type_d = WBT_TYPE_OTHER;
        end else begin
            cnt_d = clamp_upd(cnt_q, SUM_W'(nc),  SUM_W'(nw));
            lsu_d = clamp_upd(lsu_q, SUM_W'(ncl), SUM_W'(nwl));
            // Highest-indexed asserted create port wins.
            for (int unsigned i = 0; i < CREATE_PORTS; i++) begin
                if (bus.create_en[i]) begin
                    type_d = bus.create_type[i];
                end
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt_q  <= '0;
            lsu_q  <= '0;
            type_q <= WBT_TYPE_OTHER;
        end else begin
            cnt_q  <= cnt_d;
            lsu_q  <= lsu_d;
            type_q <= type_d;
        end
    end

`ifdef AQ_VIDU_WBT_PROT_CHK_EN
    logic             err_q, err_d;
    logic [SUM_W-1:0] cnt_add, lsu_add;
    logic             illegal;

    // Sticky error on overflow, underflow, or a VLSU wb with no VLSU producer.
    always_comb begin
        cnt_add = SUM_W'(cnt_q) + SUM_W'(nc);
        lsu_add = SUM_W'(lsu_q) + SUM_W'(ncl);
        illegal = (cnt_add > SUM_W'(MAX_PROD)) | (SUM_W'(nw) > cnt_add)
                | (lsu_add > SUM_W'(MAX_PROD)) | (SUM_W'(nwl) > lsu_add)
                | ((nwl != '0) & (lsu_q == '0));
        err_d   = err_q;
        if (flush) begin
            err_d = 1'b0;
        end else if (illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Same-cycle bypass: write-backs retiring every outstanding producer with no new create.
    assign bus.rd_vld      = (cnt_q == '0) | ((nc == '0) & (SUM_W'(nw) == SUM_W'(cnt_q)));
    assign bus.rd_type     = type_q;
    assign bus.rd_cnt      = cnt_q;
    assign bus.rd_lsu_pend = (lsu_q != '0);
    assign bus.full        = (cnt_q == CNT_W'(MAX_PROD));
    assign bus.wb_debug    = (cnt_q == '0);

endmodule

// File: tb/tb_aq_vidu_vid_wbt_mentry.sv
// Self-checking bench for aq_vidu_vid_wbt_mentry: directed scenarios with literal
// expectations plus an integer-arithmetic model compared on every falling edge.
// Optional feature macro: AQ_VIDU_WBT_PROT_CHK_EN (changes the expected err).
module tb_aq_vidu_vid_wbt_mentry;

    localparam int MAXP = 3;
`ifdef AQ_VIDU_WBT_PROT_CHK_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    aq_vidu_vid_wbt_mentry_if bus ();

    aq_vidu_vid_wbt_mentry dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state held as plain integers.
    int m_cnt, m_lsu, m_type, m_err;

    function automatic int clampi(input int v);
        if (v < 0)    return 0;
        if (v > MAXP) return MAXP;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int nc, nw, ncl, nwl;
        bit bad;
        if (!rst_n) begin
            m_cnt <= 0; m_lsu <= 0; m_type <= 0; m_err <= 0;
        end else if (bus.rtu_vidu_flush_wbt || bus.rtu_yy_xx_async_flush) begin
            m_cnt <= 0; m_lsu <= 0; m_type <= 0; m_err <= 0;
        end else begin
            nc  = $countones(bus.create_en);
            nw  = $countones(bus.wb_en);
            ncl = $countones(bus.create_en & bus.create_type);
            nwl = $countones(bus.wb_en & bus.wb_type);
            bad = (m_cnt + nc > MAXP) || (nw > m_cnt + nc) ||
                  (m_lsu + ncl > MAXP) || (nwl > m_lsu + ncl) || (nwl > 0 && m_lsu == 0);
            m_cnt <= clampi(m_cnt + nc - nw);
            m_lsu <= clampi(m_lsu + ncl - nwl);
            if (bus.create_en[1])      m_type <= int'(bus.create_type[1]);
            else if (bus.create_en[0]) m_type <= int'(bus.create_type[0]);
            if (bad) m_err <= 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison away from the active edge.
    always @(negedge clk) begin
        int nc, nw;
        nc = $countones(bus.create_en);
        nw = $countones(bus.wb_en);
        chk("m_rd_cnt",   int'(bus.rd_cnt),      m_cnt);
        chk("m_rd_type",  int'(bus.rd_type),     m_type);
        chk("m_lsu_pend", int'(bus.rd_lsu_pend), int'(m_lsu != 0));
        chk("m_full",     int'(bus.full),        int'(m_cnt == MAXP));
        chk("m_wb_debug", int'(bus.wb_debug),    int'(m_cnt == 0));
        chk("m_rd_vld",   int'(bus.rd_vld),      int'(m_cnt == 0 || (nc == 0 && nw == m_cnt)));
        chk("m_err",      int'(bus.err),         PROT ? m_err : 0);
    end

    task automatic drive(input logic [1:0] ce, input logic [1:0] ct,
                         input logic [1:0] we, input logic [1:0] wt,
                         input logic f1, input logic f2);
        bus.create_en = ce; bus.create_type = ct;
        bus.wb_en = we;     bus.wb_type = wt;
        bus.rtu_vidu_flush_wbt = f1; bus.rtu_yy_xx_async_flush = f2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        idle();
        #2;
        // 1: reset state
        chk("rst_rd_vld", int'(bus.rd_vld), 1);
        chk("rst_rd_cnt", int'(bus.rd_cnt), 0);
        chk("rst_full",   int'(bus.full),   0);
        chk("rst_err",    int'(bus.err),    0);
        chk("rst_wb_dbg", int'(bus.wb_debug), 1);
        chk("rst_lsu",    int'(bus.rd_lsu_pend), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 2: dual create, port1 type OTHER; dual wb bypass
        drive(2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk("t2_cnt",  int'(bus.rd_cnt), 2);
        chk("t2_lsu",  int'(bus.rd_lsu_pend), 1);
        chk("t2_type", int'(bus.rd_type), 0);
        drive(2'b00, 2'b00, 2'b11, 2'b01, 1'b0, 1'b0);
        #2 chk("t2_byp_vld", int'(bus.rd_vld), 1);
        tick();
        chk("t2_cnt0", int'(bus.rd_cnt), 0);
        chk("t2_lsu0", int'(bus.rd_lsu_pend), 0);
        chk("t2_err",  int'(bus.err), 0);

        // 3: create+wb together keeps count, blocks bypass; then fill to MAX
        drive(2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk("t3_type1", int'(bus.rd_type), 1);
        drive(2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        #2 chk("t3_vld0", int'(bus.rd_vld), 0);
        tick();
        chk("t3_cnt2", int'(bus.rd_cnt), 2);
        chk("t3_type0", int'(bus.rd_type), 0);
        drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk("t3_cnt3", int'(bus.rd_cnt), 3);
        chk("t3_full", int'(bus.full), 1);

        // 4: overflow saturates; flush clears
        drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk("t4_sat",  int'(bus.rd_cnt), 3);
        chk("t4_err",  int'(bus.err), PROT ? 1 : 0);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tick();
        chk("t4_fl_cnt", int'(bus.rd_cnt), 0);
        chk("t4_fl_err", int'(bus.err), 0);

        // 5: async-flush input overrides create+wb
        drive(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk("t5_cnt1", int'(bus.rd_cnt), 1);
        drive(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1);
        tick();
        idle();
        #1;
        chk("t5_cnt0", int'(bus.rd_cnt), 0);
        chk("t5_type", int'(bus.rd_type), 0);
        chk("t5_vld",  int'(bus.rd_vld), 1);
        chk("t5_lsu",  int'(bus.rd_lsu_pend), 0);

        // Underflow clamps; VLSU wb with no VLSU producer
        drive(2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        tick();
        chk("uf_cnt", int'(bus.rd_cnt), 0);
        chk("uf_err", int'(bus.err), PROT ? 1 : 0);
        drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tick();
        drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        drive(2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0);
        tick();
        chk("lw_cnt", int'(bus.rd_cnt), 0);
        chk("lw_err", int'(bus.err), PROT ? 1 : 0);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tick();

        // Deterministic sweep of mixed patterns, checked by the model
        for (int i = 0; i < 48; i++) begin
            drive(2'(i), 2'(i >> 2), 2'((i * 5) >> 1), 2'(i >> 3), 1'(i % 13 == 12), 1'b0);
            tick();
        end
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tick();

        // 6: async reset mid-operation
        drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        idle();
        chk("t6_cnt2", int'(bus.rd_cnt), 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cnt",  int'(bus.rd_cnt), 0);
        chk("t6_rst_vld",  int'(bus.rd_vld), 1);
        chk("t6_rst_full", int'(bus.full), 0);
        chk("t6_rst_dbg",  int'(bus.wb_debug), 1);
        chk("t6_rst_err",  int'(bus.err), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
